// File: rtl/piano_pkg.sv
// piano_pkg: note frequency table, half-period helper and FSM states for the piano tone generator
package piano_pkg;
   localparam int NOTES = 7;
   localparam int F3 [NOTES] = '{131, 147, 165, 175, 196, 220, 247};
   typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;
   function automatic int half_base(input int clk_hz, input int n);
      return clk_hz / (2 * F3[n]);
   endfunction
endpackage

// File: rtl/piano_key_decode.sv
// piano_key_decode: priority-decodes the registered key bus into octave, note and half-period
module piano_key_decode
   import piano_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int OCTAVES = 3,
   localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1,
   localparam int HW = $clog2(half_base(CLK_HZ, 0) + 1)
) (
   input  logic [OCTAVES+6:0] io_q,
   output logic               key_valid,
   output logic [OW-1:0]      octave,
   output logic [2:0]         note,
   output logic [HW-1:0]      half
);
   // eighth entry pads the table so a 3-bit index never leaves it
   localparam logic [HW-1:0] HB [8] = '{
      HW'(half_base(CLK_HZ, 0)), HW'(half_base(CLK_HZ, 1)), HW'(half_base(CLK_HZ, 2)),
      HW'(half_base(CLK_HZ, 3)), HW'(half_base(CLK_HZ, 4)), HW'(half_base(CLK_HZ, 5)),
      HW'(half_base(CLK_HZ, 6)), '0};
   always_comb begin
      octave = '0;
      note = '0;
      for (int i = 0; i < OCTAVES; i++) if (io_q[7+i]) octave = OW'(i);
      for (int i = 0; i < NOTES; i++) if (io_q[i]) note = 3'(i);
      key_valid = (|io_q[OCTAVES+6:7]) && (|io_q[6:0]);
      half = HB[note] >> octave;
   end
endmodule

// File: rtl/piano_tone_gen.sv
// piano_tone_gen: square-wave tone generator with priority key select and optional release sustain
module piano_tone_gen
   import piano_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int OCTAVES = 3,
   parameter int SUSTAIN_CYCLES = 50_000_000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [OCTAVES+6:0]              IOs,
   input  logic                            sustain_en,
   output logic                            beep,
   output logic                            note_valid,
   output logic [$clog2(OCTAVES*7)-1:0]    note_idx
);
   localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;
   localparam int CW = $clog2(half_base(CLK_HZ, 0));
   localparam int HW = $clog2(half_base(CLK_HZ, 0) + 1);
   localparam int NW = $clog2(OCTAVES * NOTES);
   localparam int SW = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
   state_t state, state_n;
   logic [OCTAVES+6:0] io_q;
   logic key_valid, load, tone_wrap, beep_n;
   logic [OW-1:0] octave;
   logic [2:0] note;
   logic [HW-1:0] half, half_q, half_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [SW-1:0] sus_cnt, sus_n;
   logic [NW-1:0] idx, idx_n;
   piano_key_decode #(.CLK_HZ(CLK_HZ), .OCTAVES(OCTAVES)) u_dec (
      .io_q(io_q), .key_valid(key_valid), .octave(octave), .note(note), .half(half));
   assign idx = NW'(octave) * NW'(NOTES) + NW'(note);
   assign tone_wrap = cnt == CW'(half_q - 1'b1);
   // a held key only reloads when it differs from the sounding one; out of SUSTAIN any key reloads
   assign load = key_valid && (state != PLAY || idx != note_idx);
   always_comb begin
      state_n = state;
      cnt_n = tone_wrap ? '0 : cnt + 1'b1;
      beep_n = beep ^ tone_wrap;
      sus_n = sus_cnt + 1'b1;
      idx_n = note_idx;
      half_n = half_q;
      if (load) begin
         state_n = PLAY;
         cnt_n = '0;
         beep_n = 1'b1;
         idx_n = idx;
         half_n = half;
      end else if (state == IDLE) begin
         cnt_n = '0;
         beep_n = 1'b0;
      end else if (state == PLAY && !key_valid) begin
         state_n = sustain_en ? SUSTAIN : IDLE;
         beep_n = sustain_en ? beep_n : 1'b0;
         sus_n = '0;
      end else if (state == SUSTAIN && sus_cnt == SW'(SUSTAIN_CYCLES - 1)) begin
         state_n = IDLE;
         beep_n = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         io_q <= '0;
         beep <= 1'b0;
         note_valid <= 1'b0;
         note_idx <= '0;
         half_q <= '0;
         cnt <= '0;
         sus_cnt <= '0;
      end else begin
         state <= state_n;
         io_q <= IOs;
         beep <= beep_n;
         note_valid <= state_n != IDLE;
         note_idx <= idx_n;
         half_q <= half_n;
         cnt <= cnt_n;
         sus_cnt <= sus_n;
      end
   end
endmodule

// File: tb/tb_piano_tone_gen.sv
// tb_piano_tone_gen: directed scoreboard bench for the piano tone generator at a scaled clock rate
module tb_piano_tone_gen;
   localparam int CLK_HZ = 100_000;
   localparam int OCTAVES = 3;
   localparam int SUS = 1000;
   localparam int FREQ [7] = '{131, 147, 165, 175, 196, 220, 247};
   typedef struct { int idx; int half; } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sustain_en = 1'b0;
   logic [OCTAVES+6:0] IOs = '0;
   logic beep, note_valid;
   logic [4:0] note_idx;
   int n_chk = 0;
   int n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   piano_tone_gen #(.CLK_HZ(CLK_HZ), .OCTAVES(OCTAVES), .SUSTAIN_CYCLES(SUS)) dut (
      .clk(clk), .reset(reset), .IOs(IOs), .sustain_en(sustain_en),
      .beep(beep), .note_valid(note_valid), .note_idx(note_idx));

   function automatic int model_half(input int oct, input int n);
      return (CLK_HZ / (2 * FREQ[n])) >> oct;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic measure(input logic lvl, output int n);
      n = 1;
      tick();
      while (beep === lvl && n < 2000) begin
         n++;
         tick();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_beep"}, beep, 0);
      chk({tag, "_valid"}, note_valid, 0);
      chk({tag, "_idx"}, note_idx, 0);
   endtask

   // drive a key, expect the tone two edges later and measure one full period
   task automatic press(input logic [OCTAVES+6:0] io, input int oct, input int n, output int hi);
      exp_t e;
      int lo;
      IOs = io;
      sb.push_back('{oct * 7 + n, model_half(oct, n)});
      tick(2);
      e = sb.pop_front();
      chk("press_beep", beep, 1);
      chk("press_valid", note_valid, 1);
      chk("press_idx", note_idx, e.idx);
      measure(1'b1, hi);
      chk("half_high", hi, e.half);
      measure(1'b0, lo);
      chk("half_low", lo, e.half);
   endtask

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1);
   end

   initial begin
      int hi, h;
      logic ev;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i % 250 == 249) chk_zero("in_reset");
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_zero("idle");
      end
      for (int o = 0; o < OCTAVES; o++)
         for (int n = 0; n < 7; n++) begin
            press((OCTAVES + 7)'((1 << (7 + o)) | (1 << n)), o, n, hi);
            if (o == 0 && n == 0) chk("low_do", hi, 381);
            if (o == 2 && n == 6) chk("high_si", hi, 50);
         end
      press(10'b110_0100001, 2, 5, hi);
      chk("multi_la", hi, 56);
      IOs = 10'b000_1000000;
      tick(2);
      chk("nokey_beep", beep, 0);
      chk("nokey_valid", note_valid, 0);
      chk("nokey_idx", note_idx, 19);
      press(10'b010_0000001, 1, 0, hi);
      tick(50);
      press(10'b010_0000010, 1, 1, hi);
      chk("med_re", hi, 170);
      // land the retrigger exactly on the Re high-to-low toggle edge
      tick(model_half(1, 1) - 2);
      press(10'b010_0000001, 1, 0, hi);
      sustain_en = 1'b1;
      press(10'b010_0000100, 1, 2, hi);
      h = model_half(1, 2);
      tick(10);
      IOs = '0;
      for (int j = 11; j <= 12 + SUS; j++) begin
         tick();
         ev = j < 12 + SUS;
         chk("sus_valid", note_valid, ev);
         chk("sus_beep", beep, ev && ((j / h) % 2 == 0));
         if (j == 500) sustain_en = 1'b0;
      end
      chk("sus_idx", note_idx, 9);
      sustain_en = 1'b1;
      press(10'b010_0000100, 1, 2, hi);
      tick(1);
      IOs = '0;
      tick(400);
      chk("sus2_valid", note_valid, 1);
      press(10'b010_0001000, 1, 3, hi);
      tick(800);
      chk("fa_held_valid", note_valid, 1);
      chk("fa_held_idx", note_idx, 10);
      reset = 1'b1;
      IOs = '0;
      tick();
      chk_zero("rst_play");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_zero("post_rst_play");
      end
      press(10'b010_0000100, 1, 2, hi);
      IOs = '0;
      tick(300);
      chk("pre_rst_sus_valid", note_valid, 1);
      reset = 1'b1;
      tick();
      chk_zero("rst_sus");
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_zero("post_rst_sus");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
